// File: rtl/uart_operand_rx.sv
// uart_operand_rx: 8N1 UART receiver for the register file's serial-input port.
// The line is oversampled 16x using a tick every DIV clocks. Each accepted byte
// appears on rx_data with a one-clock signal strobe. flag alternates between
// bytes so that consecutive bytes go to operand registers $16 and $17.
module uart_operand_rx #(
  parameter int DIV = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       pair_clr,
  output logic [7:0] rx_data,
  output logic       signal,
  output logic       flag,
  output logic       frame_err
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        signal_q, signal_d;
  logic        frame_err_q, frame_err_d;
  logic        slot_q, slot_d;
  logic        tick_s;

  // Two-stage synchroniser on the raw pin; only rx_s_q is used downstream.
  always_comb begin
    sync1_d = uart_rx;
    rx_s_d  = sync1_q;
  end

  // One oversample tick on the last clock of each DIV-long period.
  always_comb begin
    tick_s = (div_q == DIV_LAST);
  end

  // Receive state machine: next state, counters, shift register and strobes.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    s_d         = s_q;
    n_d         = n_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    signal_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = 16'd0;
        if (rx_s_q == 1'b0) begin
          state_d = ST_START;
          s_d     = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        div_d = tick_s ? 16'd0 : (div_q + 16'd1);
        if (tick_s) begin
          if (s_q == 4'd7) begin
            // Mid start bit: a high line here means the edge was a glitch.
            s_d = 4'd0;
            if (rx_s_q == 1'b0) begin
              state_d = ST_DATA;
              n_d     = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end

      ST_DATA: begin
        div_d = tick_s ? 16'd0 : (div_q + 16'd1);
        if (tick_s) begin
          if (s_q == 4'd15) begin
            sh_d = {rx_s_q, sh_q[7:1]};
            s_d  = 4'd0;
            if (n_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end

      ST_STOP: begin
        div_d = tick_s ? 16'd0 : (div_q + 16'd1);
        if (tick_s) begin
          if (s_q == 4'd15) begin
            s_d = 4'd0;
            if (rx_s_q == 1'b1) begin
              rx_data_d = sh_q;
              signal_d  = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit.
        div_d = 16'd0;
        if (rx_s_q == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = 16'd0;
        s_d     = 4'd0;
        n_d     = 3'd0;
      end
    endcase
  end

  // Operand slot: toggles as signal drops so flag is stable during the strobe;
  // pair_clr wins over the toggle.
  always_comb begin
    if (pair_clr) begin
      slot_d = 1'b1;
    end else if (signal_q) begin
      slot_d = ~slot_q;
    end else begin
      slot_d = slot_q;
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      div_q       <= 16'd0;
      s_q         <= 4'd0;
      n_q         <= 3'd0;
      sh_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      signal_q    <= 1'b0;
      frame_err_q <= 1'b0;
      slot_q      <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      div_q       <= div_d;
      s_q         <= s_d;
      n_q         <= n_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      signal_q    <= signal_d;
      frame_err_q <= frame_err_d;
      slot_q      <= slot_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign signal    = signal_q;
  assign flag      = slot_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/uart_operand_rx.md
# uart_operand_rx

UART receiver that feeds the register file's serial-input port. It deserialises 8N1 frames from the board RX pin and presents each byte on `rx_data` with a one-cycle `signal` strobe. It also drives `flag`, which alternates so that consecutive bytes land in operand registers $16 and $17. The block sits between the board pin and the register file; the register file samples `signal`, `flag` and `rx_data` on the falling clock edge.

## Interface
- `DIV`, default 651: clk cycles per oversample tick; baud = f_clk / (16·DIV), so 651 gives about 9600 baud at 100 MHz. Legal range is 2..65535.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `uart_rx` input, 1 bit: asynchronous serial line; idles high.
- `pair_clr` input, 1 bit: synchronous; forces the next accepted byte to have `flag`=1.
- `rx_data` output, 8 bits: last accepted byte; held until the next accepted byte.
- `signal` output, 1 bit: one-clk pulse marking a new `rx_data`.
- `flag` output, 1 bit: 1 means the byte is for $16 (first operand); 0 means $17 (second operand).
- `frame_err` output, 1 bit: one-clk pulse when a stop bit samples low.

## Operation
- **Synchroniser:** two flops on `uart_rx`, both reset to 1. Output `rx_s` is used everywhere; the raw pin is never used.
- **Tick generator:** `div` counts 0..DIV-1. `tick` is asserted when `div`==DIV-1, and `div` then wraps to 0. `div` is held at 0 in IDLE and in WAIT_HIGH.
- **Sample counter:** `s`, 4 bits. Bit index `n`, 0..7. Shift register `sh`, 8 bits.
- **IDLE:** if `rx_s`==0, go to START with `s`=0 and `div`=0.
- **START:** on tick, `s` increments. On the tick with `s`==7 (mid start bit):
  - if `rx_s`==0, go to DATA with `s`=0 and `n`=0;
  - else it is a glitch: return to IDLE with no outputs.
- **DATA:** on tick, `s` increments. On the tick with `s`==15:
  - sample `rx_s` into `sh` LSB-first (`sh` <= {`rx_s`, `sh`[7:1]});
  - `s`=0;
  - if `n`==7, go to STOP, else `n` increments.
- **STOP:** on the tick with `s`==15:
  - if `rx_s`==1: `rx_data`<=`sh`, `signal`<=1, go to IDLE;
  - if `rx_s`==0: `frame_err`<=1, `rx_data` is unchanged, `flag` is unchanged, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- **Pairing:** internal `slot` drives `flag` directly. `slot` resets to 1 and toggles on the rising edge that deasserts `signal`, so `flag` is stable throughout the `signal` cycle.
- **pair_clr:** sets `slot` to 1 and has priority over the toggle. It has no effect on the receive state machine or on a byte in flight.

## Timing
- **Reset values:** `rx_data`=8'h00, `signal`=0, `flag`=1, `frame_err`=0, state=IDLE, `s`=`n`=`div`=0, synchroniser flops=1.
- **Reset mid-frame:** the byte is dropped. After release, the receiver waits in IDLE for a new falling edge; a line still low at release starts a new frame.
- **Bit period** = 16·DIV clk.
- **Latency:** from the pin falling edge at the start bit to `signal` high is 2 (sync) + 1 (IDLE→START) + (8+16·8+16)·DIV clk. That is 152·DIV + 3 clk, ±1 clk for pin-edge alignment.
- **`signal`:** high for exactly one clk, launched on a rising edge, so the register file's negedge sample sees it once.
- **Back-to-back frames:** a new start bit may fall immediately after the stop sample. The minimum spacing between `signal` pulses is 152·DIV + 1 clk; there is no overrun path.
- **`frame_err`:** launched on the same edge where `signal` would have been; the two are never high together.
- **`pair_clr` together with the `signal` deassert edge:** `slot` becomes 1; no toggle occurs.

## Test plan
Run with DIV=4, so the bit period is 64 clk.

- **Reset:** hold `reset` low for 5 clk with `uart_rx`=1. Expect `rx_data`=00, `signal`=0, `flag`=1, `frame_err`=0; no strobe for 2000 clk after release.
- **Single byte:** send 0xA5. Expect exactly one `signal` pulse with `rx_data`=A5 and `flag`=1. `flag` reads 0 on the next clk. Latency is 611 ± 1 clk from the start edge.
- **Back-to-back bytes:** send 0x3C, 0xC3, 0xFF with zero idle between frames. Expect pulses carrying 3C/`flag`=1, C3/`flag`=0, FF/`flag`=1, spaced 640 clk apart.
- **Glitch rejection:** apply a 20-clk low pulse on an idle line. Expect a return to IDLE, no `signal`, no `frame_err`, and `flag` unchanged. A following 0x12 is received correctly.
- **Framing error:** send 0x55 with a low stop bit, then hold the line low for 300 clk. Expect one `frame_err` pulse, no `signal`, `rx_data` unchanged and `flag` unchanged. The receiver stays in WAIT_HIGH; after the line goes high, 0x01 is received with the same `flag`.
- **pair_clr and reset mid-frame:**
  - receive 0x10 (`flag`=1), pulse `pair_clr`, receive 0x20: expect `flag`=1 again;
  - assert `reset` during data bit 4 of 0x77: expect no strobe; the next 0x88 is received with `flag`=1.
